// File: rtl/icon_sprite_engine_if.sv
// Pixel-stream, sprite-control and ROM-side signal bundle for icon_sprite_engine.
// The blink input exists only when ICON_BLINK_EN is defined.
interface icon_sprite_engine_if #(
  parameter int ICON_LOG2 = 5,
  parameter int COLOR_W   = 2
);
  logic                   frame_start;
  logic [11:0]            pix_row;
  logic [11:0]            pix_col;
  logic [7:0]             loc_x;
  logic [7:0]             loc_y;
  logic [2:0]             orient;
  logic                   sprite_en;
  logic [2*ICON_LOG2:0]   rom_addr;
  logic [COLOR_W-1:0]     rom_data;
  logic                   icon_hit;
  logic [COLOR_W-1:0]     icon_out;
`ifdef ICON_BLINK_EN
  logic                   blink;
`endif

  modport master (
    output frame_start, pix_row, pix_col, loc_x, loc_y, orient, sprite_en, rom_data,
`ifdef ICON_BLINK_EN
    output blink,
`endif
    input  rom_addr, icon_hit, icon_out
  );

  modport slave (
    input  frame_start, pix_row, pix_col, loc_x, loc_y, orient, sprite_en, rom_data,
`ifdef ICON_BLINK_EN
    input  blink,
`endif
    output rom_addr, icon_hit, icon_out
  );
endinterface

// File: rtl/icon_sprite_engine.sv
// Orientation-aware sprite overlay: window hit, source-address rotation, external ROM
// fetch and latency-aligned colour/hit output. Optional frame blink via ICON_BLINK_EN.
module icon_sprite_engine #(
  parameter int ICON_LOG2 = 5,
  parameter int ZOOM_LOG2 = 0,
  parameter int COLOR_W   = 2,
  parameter int SCALE_X   = 8,
  parameter int SCALE_Y   = 6,
  parameter int ROM_LAT   = 1
`ifdef ICON_BLINK_EN
  ,
  parameter int BLINK_LOG2 = 4
`endif
) (
  input logic                  clk,
  input logic                  reset,
  icon_sprite_engine_if.slave  bus
);
  localparam int S    = 1 << ICON_LOG2;
  localparam int EDGE = S << ZOOM_LOG2;
  localparam int AW   = 2 * ICON_LOG2 + 1;
  localparam logic signed [12:0]    EDGE_S = 13'(EDGE);
  localparam logic [ICON_LOG2-1:0]  M      = {ICON_LOG2{1'b1}};

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;
  state_t state_r, state_nxt_s;

  logic [11:0]          px_r, py_r, px_new_s, py_new_s, px_eff_s, py_eff_s;
  logic [2:0]           orient_r, orient_eff_s;
  logic                 en_r, en_eff_s, run_eff_s;
  logic signed [12:0]   dr_s, dc_s;
  logic [ICON_LOG2-1:0] r_s, c_s, sr_s, sc_s;
  logic                 win_s, blank_s, hit_s, hit_r;
  logic [ROM_LAT-1:0]   hit_pipe_r;

  // Next-state logic: leave IDLE on the first frame pulse, then stay in RUN
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.frame_start) state_nxt_s = RUN;
        else                 state_nxt_s = IDLE;
      end
      RUN:     state_nxt_s = RUN;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Window hit and source-coordinate rotation; a frame pulse pixel sees the new frame values
  always_comb begin
    px_new_s = 12'(int'(bus.loc_x) * SCALE_X);
    py_new_s = 12'(int'(bus.loc_y) * SCALE_Y);
    if (bus.frame_start) begin
      px_eff_s     = px_new_s;
      py_eff_s     = py_new_s;
      orient_eff_s = bus.orient;
      en_eff_s     = bus.sprite_en;
    end else begin
      px_eff_s     = px_r;
      py_eff_s     = py_r;
      orient_eff_s = orient_r;
      en_eff_s     = en_r;
    end
    run_eff_s = bus.frame_start || (state_r == RUN);
    dr_s  = $signed({1'b0, bus.pix_row}) - $signed({1'b0, py_eff_s});
    dc_s  = $signed({1'b0, bus.pix_col}) - $signed({1'b0, px_eff_s});
    win_s = run_eff_s && (dr_s >= 13'sd0) && (dr_s < EDGE_S)
                      && (dc_s >= 13'sd0) && (dc_s < EDGE_S);
    r_s = ICON_LOG2'(dr_s >>> ZOOM_LOG2);
    c_s = ICON_LOG2'(dc_s >>> ZOOM_LOG2);
    case (orient_eff_s[2:1])
      2'd0:    begin sr_s = r_s;     sc_s = c_s;     end
      2'd1:    begin sr_s = M - c_s; sc_s = r_s;     end
      2'd2:    begin sr_s = M - r_s; sc_s = M - c_s; end
      2'd3:    begin sr_s = c_s;     sc_s = M - r_s; end
      default: begin sr_s = r_s;     sc_s = c_s;     end
    endcase
    hit_s = win_s && en_eff_s && !blank_s;
  end

`ifdef ICON_BLINK_EN
  logic [BLINK_LOG2-1:0] blink_cnt_r, blink_cnt_eff_s;

  // Frame counter advance and blink blanking for the current frame
  always_comb begin
    if (bus.frame_start && (state_r == RUN)) blink_cnt_eff_s = blink_cnt_r + BLINK_LOG2'(1);
    else                                     blink_cnt_eff_s = blink_cnt_r;
    blank_s = bus.blink && blink_cnt_eff_s[BLINK_LOG2-1];
  end

  // Blink frame counter register
  always_ff @(posedge clk) begin
    if (!reset) blink_cnt_r <= {BLINK_LOG2{1'b0}};
    else        blink_cnt_r <= blink_cnt_eff_s;
  end
`else
  assign blank_s = 1'b0;
`endif

  // FSM state and once-per-frame latch of position, orientation and enable
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= IDLE;
      px_r     <= 12'd0;
      py_r     <= 12'd0;
      orient_r <= 3'd0;
      en_r     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (bus.frame_start) begin
        px_r     <= px_new_s;
        py_r     <= py_new_s;
        orient_r <= bus.orient;
        en_r     <= bus.sprite_en;
      end
    end
  end

  // Stage-1 address/hit, hit delay matching the ROM, and output register
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.rom_addr <= {AW{1'b0}};
      hit_r        <= 1'b0;
      hit_pipe_r   <= {ROM_LAT{1'b0}};
      bus.icon_hit <= 1'b0;
      bus.icon_out <= {COLOR_W{1'b0}};
    end else begin
      bus.rom_addr <= win_s ? {orient_eff_s[0], sr_s, sc_s} : {AW{1'b0}};
      hit_r        <= hit_s;
      hit_pipe_r   <= ROM_LAT'({hit_pipe_r, hit_r});
      bus.icon_hit <= hit_pipe_r[ROM_LAT-1];
      bus.icon_out <= hit_pipe_r[ROM_LAT-1] ? bus.rom_data : {COLOR_W{1'b0}};
    end
  end
endmodule
